ex_mem_arbiter: RTL

//  Shares the core's single data-side bus port (rib_ex_*) between NUM_REQ

---
 rtl/ex_mem_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ex_mem_arbiter.sv
// Round-robin arbiter sharing the core's data-side rib port between ex (port 0)
// and the send/fire accelerators, with burst lock bounded by a fairness limit.
module ex_mem_arbiter #(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [NUM_REQ-1:0]    we_i,
    input  logic [NUM_REQ*AW-1:0] addr_i,
    input  logic [NUM_REQ*DW-1:0] wdata_i,
    output logic [NUM_REQ-1:0]    gnt_o,
    output logic [NUM_REQ-1:0]    ack_o,
    output logic [DW-1:0]         rdata_o,
    output logic [AW-1:0]         bus_addr_o,
    output logic [DW-1:0]         bus_wdata_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    input  logic [DW-1:0]         bus_rdata_i,
    input  logic                  bus_hold_i,
    output logic                  hold_ex_o
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]      burst_cnt_q, burst_cnt_d;

    logic [IW-1:0]      gidx;
    logic [IW-1:0]      nxt_ptr;
    logic [AW-1:0]      addr_mux;
    logic [DW-1:0]      wdata_mux;
    logic               we_mux;
    logic               own_req;
    logic               ack_any;
    logic               others;
    logic               burst_done;
    logic               cnt_sat;

    // First set request scanning upward from ptr, wrapping at NUM_REQ.
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                   input logic [IW-1:0]      ptr);
        logic [NUM_REQ-1:0] win;
        int unsigned        k;
        win = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = 32'(ptr) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (win == '0 && req[IW'(k)]) win[IW'(k)] = 1'b1;
        end
        return win;
    endfunction

    // Granted slot index and its bus payload; all-zero when nothing is granted.
    always_comb begin
        gidx      = '0;
        addr_mux  = '0;
        wdata_mux = '0;
        we_mux    = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) begin
                gidx      = IW'(i);
                addr_mux  = addr_i[i*AW +: AW];
                wdata_mux = wdata_i[i*DW +: DW];
                we_mux    = we_i[i];
            end
        end
    end

    assign nxt_ptr    = (32'(gidx) == NUM_REQ - 1) ? '0 : gidx + IW'(1);
    assign own_req    = |(gnt_q & req_i);
    assign ack_any    = own_req & ~bus_hold_i;
    assign others     = |(req_i & ~gnt_q);
    assign cnt_sat    = (32'(burst_cnt_q) >= MAX_BURST);
    // A saturated count still yields as soon as someone else is waiting.
    assign burst_done = (MAX_BURST != 0) && (32'(burst_cnt_q) + 32'd1 >= MAX_BURST);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    state_d     = ST_OWN;
                    gnt_d       = rr_pick(req_i, rr_ptr_q);
                    burst_cnt_d = '0;
                end
            end
            ST_OWN: begin
                if (!own_req) begin
                    rr_ptr_d    = nxt_ptr;
                    gnt_d       = rr_pick(req_i, nxt_ptr);
                    state_d     = (|req_i) ? ST_OWN : ST_IDLE;
                    burst_cnt_d = '0;
                end else if (ack_any) begin
                    if (burst_done && others) begin
                        rr_ptr_d    = nxt_ptr;
                        gnt_d       = rr_pick(req_i & ~gnt_q, nxt_ptr);
                        burst_cnt_d = '0;
                    end else if (!cnt_sat) begin
                        burst_cnt_d = burst_cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign ack_o       = gnt_q & req_i & {NUM_REQ{~bus_hold_i}};
    assign rdata_o     = bus_rdata_i;
    assign bus_req_o   = own_req;
    assign bus_we_o    = we_mux & own_req;
    assign bus_addr_o  = addr_mux;
    assign bus_wdata_o = wdata_mux;
    assign hold_ex_o   = req_i[0] & ~gnt_q[0];

endmodule
